// File: rtl/poly_eval_scheduler.sv
// Shared quadratic evaluator: R = A*X*X + B*X + C (mod 2^W),
// one ALU time-shared by NREQ round-robin requesters.
module poly_eval_scheduler #(
  parameter  int NREQ = 4,
  parameter  int W    = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0][W-1:0]     req_a,
  input  logic [NREQ-1:0][W-1:0]     req_b,
  input  logic [NREQ-1:0][W-1:0]     req_c,
  input  logic [NREQ-1:0][W-1:0]     req_x,
  output logic [NREQ-1:0]            req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [W-1:0]               rsp_data,
  output logic [IDW-1:0]             rsp_id,
  output logic                       busy,
  output logic [15:0]                jobs_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_AX,
    S_MUL_AXX,
    S_MUL_BX,
    S_ADD_B,
    S_ADD_C,
    S_RESP
  } state_t;

  state_t         state_q;
  state_t         state_d;

  logic [W-1:0]   ra;
  logic [W-1:0]   rb;
  logic [W-1:0]   rc;
  logic [W-1:0]   rx;
  logic [IDW-1:0] id_q;
  logic [IDW-1:0] rr_last;

  logic           grant_hit;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] cand;
  logic           accept;

  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic           alu_mul;
  logic [W-1:0]   alu_y;

  // Round-robin search starting just after the last winner.
  always_comb begin
    grant_hit = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDW'((int'(rr_last) + i) % NREQ);
      if (!grant_hit && req_valid[cand]) begin
        grant_hit = 1'b1;
        grant_id  = cand;
      end
    end
  end

  assign accept = (state_q == S_IDLE) && grant_hit;

  // One-hot ready, only offered while the engine is idle.
  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: fixed five compute steps, then hold in RESP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = S_MUL_AX;
      S_MUL_AX:  state_d = S_MUL_AXX;
      S_MUL_AXX: state_d = S_MUL_BX;
      S_MUL_BX:  state_d = S_ADD_B;
      S_ADD_B:   state_d = S_ADD_C;
      S_ADD_C:   state_d = S_RESP;
      S_RESP:    if (rsp_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Operand select for the single shared ALU.
  always_comb begin
    alu_a   = ra;
    alu_b   = rx;
    alu_mul = 1'b1;
    case (state_q)
      S_MUL_BX: begin
        alu_a = rb;
      end
      S_ADD_B: begin
        alu_b   = rb;
        alu_mul = 1'b0;
      end
      S_ADD_C: begin
        alu_b   = rc;
        alu_mul = 1'b0;
      end
      default: ;
    endcase
  end

  assign alu_y = alu_mul ? alu_a * alu_b
                         : alu_a + alu_b;

  // Operand capture, ALU write-back, response and job counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      ra        <= '0;
      rb        <= '0;
      rc        <= '0;
      rx        <= '0;
      id_q      <= '0;
      rr_last   <= IDW'(NREQ - 1);
      rsp_data  <= '0;
      rsp_id    <= '0;
      jobs_done <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            ra      <= req_a[grant_id];
            rb      <= req_b[grant_id];
            rc      <= req_c[grant_id];
            rx      <= req_x[grant_id];
            id_q    <= grant_id;
            rr_last <= grant_id;
          end
        end
        S_MUL_AX:  ra <= alu_y;
        S_MUL_AXX: ra <= alu_y;
        S_MUL_BX:  rb <= alu_y;
        S_ADD_B:   ra <= alu_y;
        S_ADD_C: begin
          rsp_data <= alu_y;
          rsp_id   <= id_q;
        end
        S_RESP: begin
          if (rsp_ready) begin
            jobs_done <= jobs_done + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);

endmodule
